regfile_wb_arbiter: RTL

Round-robin arbiter that shares the register file's single write port among NREQ writeback requesters (ALU, load unit, mul/div unit). It accepts at most one write per cycle through valid/ready handshakes and registers the winner onto the register file write inputs (regwrite, wr_in, write_data_in). It also provides forwarding hit flags for the two read ports, covering the one cycle in which a granted write is in flight.

---
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port.
// Also flags read-port forwarding hits against the in-flight write.
module regfile_wb_arbiter #(
   parameter int W    = 32,
   parameter int NREQ = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              freeze,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [5*NREQ-1:0] req_addr,
   input  logic [W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              regwrite,
   output logic [4:0]        wr_out,
   output logic [W-1:0]      wdata_out,
   input  logic [4:0]        rr1_in,
   input  logic [4:0]        rr2_in,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [15:0]       write_count
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   win;
   logic [IW-1:0]   cand;
   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [4:0]      waddr;
   logic [W-1:0]    wdata;

   logic            regwrite_q, regwrite_d;
   logic [4:0]      wr_q, wr_d;
   logic [W-1:0]    wd_q, wd_d;
   logic [15:0]     cnt_q, cnt_d;

   // Scan upward from the slot after the last winner, wrapping.
   always_comb begin
      grant = '0;
      xfer  = 1'b0;
      win   = last_q;
      cand  = '0;
      if (!reset && !freeze) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!xfer && req_valid[cand]) begin
               xfer        = 1'b1;
               grant[cand] = 1'b1;
               win         = cand;
            end
         end
      end
   end

   assign waddr = req_addr[5*int'(win) +: 5];
   assign wdata = req_data[W*int'(win) +: W];

   always_comb begin
      last_d     = xfer ? win : last_q;
      regwrite_d = xfer && (waddr != 5'd0);
      wr_d       = regwrite_d ? waddr : wr_q;
      wd_d       = regwrite_d ? wdata : wd_q;
      cnt_d      = cnt_q + {15'd0, regwrite_q};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q     <= IW'(NREQ - 1);
         regwrite_q <= 1'b0;
         wr_q       <= '0;
         wd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         last_q     <= last_d;
         regwrite_q <= regwrite_d;
         wr_q       <= wr_d;
         wd_q       <= wd_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ready   = grant;
   assign regwrite    = regwrite_q;
   assign wr_out      = wr_q;
   assign wdata_out   = wd_q;
   assign write_count = cnt_q;
   assign fwd1_hit    = regwrite_q && (wr_q == rr1_in) && (rr1_in != 5'd0);
   assign fwd2_hit    = regwrite_q && (wr_q == rr2_in) && (rr2_in != 5'd0);

endmodule
